// File: rtl/fifo_rd_framer_pkg.sv
// Shared PUSCH framing constants and the read-framer state encoding.
package fifo_rd_framer_pkg;

    localparam int PUSCH_PKT_LEN = 3276;   // words per OFDM symbol packet
    localparam int PUSCH_SYM_NUM = 14;     // symbols per slot

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_RUN   = ST_RUN,
        S_DRAIN = ST_DRAIN
    } state_t;

endpackage

// File: rtl/fifo_rd_framer_skid.sv
// Two-entry in-order buffer; entry 0 is always the head.
module skid_buf2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [1:0]   occ,
    output logic [W-1:0] head
);

    logic [W-1:0] mem [2];
    logic         wr_idx;

    // A simultaneous pop from one entry lands the new word straight in the head slot.
    assign wr_idx = ~((occ == 2'd0) | ((occ == 2'd1) & pop));
    assign head   = mem[0];

    // Storage: shift on pop, then write the incoming word at the tail.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
        end else begin
            if (pop)
                mem[0] <= mem[1];
            if (push)
                mem[wr_idx] <= din;
        end
    end

    // Occupancy: push and pop together leave it unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            occ <= 2'd0;
        else if (clr)
            occ <= 2'd0;
        else if (push & ~pop)
            occ <= occ + 2'd1;
        else if (pop & ~push)
            occ <= occ - 2'd1;
    end

endmodule

// File: rtl/fifo_rd_framer.sv
// Read-side framer: pops the show-ahead FIFO, tags sop/eop/symbol index,
// and streams words out through a 2-entry buffer with packet-aligned start/stop.
module fifo_rd_framer
    import fifo_rd_framer_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int PKT_LEN    = PUSCH_PKT_LEN,
    parameter int SYM_NUM    = PUSCH_SYM_NUM
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic                       clr,
    input  logic [DATA_WIDTH-1:0]      fifo_dout,
    input  logic                       fifo_empty,
    output logic                       fifo_rd_en,
    output logic [DATA_WIDTH-1:0]      m_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic                       m_sop,
    output logic                       m_eop,
    output logic [$clog2(SYM_NUM)-1:0] m_sym_idx,
    output logic                       busy,
    output logic [15:0]                underrun_cnt
);

    localparam int SYM_W = $clog2(SYM_NUM);
    localparam int CNT_W = $clog2(PKT_LEN);
    localparam int ENT_W = DATA_WIDTH + 2 + SYM_W;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PKT_LEN - 1);
    localparam logic [SYM_W-1:0] SYM_LAST = SYM_W'(SYM_NUM - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] word_cnt;
    logic [SYM_W-1:0] sym_idx;
    logic [1:0]       occ;
    logic             pop_word, last_word, retire, pkt_done;
    logic [ENT_W-1:0] push_ent, head;

    // Pops depend only on registered state/occ, so m_ready never feeds the FIFO read port.
    assign fifo_rd_en = (state != S_IDLE) & ~fifo_empty & (occ != 2'd2) & ~clr;
    assign pop_word   = fifo_rd_en;
    assign last_word  = (word_cnt == CNT_LAST);
    assign retire     = m_valid & m_ready;
    assign m_valid    = (occ != 2'd0);
    assign busy       = (state != S_IDLE) | m_valid;

    assign push_ent = {(word_cnt == '0), last_word, sym_idx, fifo_dout};
    assign {m_sop, m_eop, m_sym_idx, m_data} = head;

    skid_buf2 #(.W(ENT_W)) u_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .push  (pop_word),
        .pop   (retire),
        .din   (push_ent),
        .occ   (occ),
        .head  (head)
    );

    // Packet boundary reached after this cycle: either nothing in flight, or the eop is popping now.
    // A sop popped in the same cycle en falls sends RUN to DRAIN so the packet is completed.
    assign pkt_done = ((word_cnt == '0) & ~pop_word) | (pop_word & last_word);

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (en) state_nxt = S_RUN;
            S_RUN:   if (!en) state_nxt = pkt_done ? S_IDLE : S_DRAIN;
            S_DRAIN: begin
                if (en)
                    state_nxt = S_RUN;
                else if (pop_word & last_word)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else if (clr)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Word and symbol counters advance on each pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt <= '0;
            sym_idx  <= '0;
        end else if (clr) begin
            word_cnt <= '0;
            sym_idx  <= '0;
        end else if (pop_word) begin
            if (last_word) begin
                word_cnt <= '0;
                sym_idx  <= (sym_idx == SYM_LAST) ? '0 : sym_idx + 1'b1;
            end else begin
                word_cnt <= word_cnt + 1'b1;
            end
        end
    end

    // Underrun: mid-packet, FIFO empty and nothing left to present downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            underrun_cnt <= '0;
        else if (clr)
            underrun_cnt <= '0;
        else if ((state != S_IDLE) && (word_cnt != '0) && fifo_empty && (occ == 2'd0)
                 && (underrun_cnt != 16'hFFFF))
            underrun_cnt <= underrun_cnt + 16'd1;
    end

endmodule

// File: tb/tb_fifo_rd_framer.sv
// Randomized bench for fifo_rd_framer against a queue-based stream model.
module tb_fifo_rd_framer;

    localparam int DW = 16;
    localparam int L  = 4;
    localparam int S  = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0, clr = 1'b0, m_ready = 1'b0, fifo_empty = 1'b1;
    logic [DW-1:0] fifo_dout = '0;
    logic          fifo_rd_en, m_valid, m_sop, m_eop, busy;
    logic [DW-1:0] m_data;
    logic [1:0]    m_sym_idx;
    logic [15:0]   underrun_cnt;

    always #5 clk = ~clk;

    fifo_rd_framer #(.DATA_WIDTH(DW), .PKT_LEN(L), .SYM_NUM(S)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .clr          (clr),
        .fifo_dout    (fifo_dout),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .m_data       (m_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_sop        (m_sop),
        .m_eop        (m_eop),
        .m_sym_idx    (m_sym_idx),
        .busy         (busy),
        .underrun_cnt (underrun_cnt)
    );

    typedef struct {
        logic [DW-1:0] d;
        logic          sop;
        logic          eop;
        logic [1:0]    sym;
    } exp_t;

    exp_t          sb[$];   // words popped, not yet accepted downstream
    logic [DW-1:0] fq[$];   // show-ahead FIFO contents
    int n_chk = 0, n_err = 0;
    int pops = 0, outst = 0, ucnt = 0, accs = 0, cyc = 0;
    int first_acc = -1, last_acc = -1;
    bit en_n = 0, rdy_n = 0, clr_n = 0;
    logic last_rd;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // One clock: apply inputs, check outputs, advance the model to the next edge.
    task automatic cycle();
        exp_t e;
        logic rd, vld, emp;
        @(negedge clk);
        en = en_n; m_ready = rdy_n; clr = clr_n;
        fifo_empty = (fq.size() == 0);
        fifo_dout  = fifo_empty ? '0 : fq[0];
        #1;
        cyc++;
        rd = fifo_rd_en; vld = m_valid; emp = fifo_empty; last_rd = rd;
        chk("ucnt", underrun_cnt, ucnt);
        chk("valid", vld, outst != 0);
        if (outst != 0) chk("busy", busy, 1);
        if (outst == 2 || emp || clr) chk("rd_en_blk", rd, 0);
        if (vld && sb.size() != 0) begin
            e = sb[0];
            chk("data", m_data, e.d);
            chk("sop", m_sop, e.sop);
            chk("eop", m_eop, e.eop);
            chk("sym", m_sym_idx, e.sym);
        end
        if (clr) begin
            sb.delete(); outst = 0; pops = 0; ucnt = 0;
        end else begin
            if (emp && outst == 0 && (pops % L) != 0 && ucnt < 65535) ucnt++;
            if (vld && m_ready && outst > 0) begin
                void'(sb.pop_front()); outst--; accs++;
                if (first_acc < 0) first_acc = cyc;
                last_acc = cyc;
            end
            if (rd && !emp) begin
                e.d = fq.pop_front();
                e.sop = ((pops % L) == 0);
                e.eop = ((pops % L) == L - 1);
                e.sym = 2'((pops / L) % S);
                sb.push_back(e);
                pops++; outst++;
            end
        end
    endtask

    task automatic drain(input string tag, input int bound);
        int n = 0;
        while ((fq.size() != 0 || outst != 0) && n < bound) begin cycle(); n++; end
        if (n >= bound) chk(tag, fq.size() + outst, 0);
    endtask

    initial begin
        int base, n;
        // Reset state
        #2;
        chk("rst_valid", m_valid, 0); chk("rst_data", m_data, 0);
        chk("rst_sop", m_sop, 0); chk("rst_eop", m_eop, 0);
        chk("rst_sym", m_sym_idx, 0); chk("rst_rd_en", fifo_rd_en, 0);
        chk("rst_busy", busy, 0); chk("rst_ucnt", underrun_cnt, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Preloaded burst: 12 words back to back
        for (int i = 0; i < 12; i++) fq.push_back(DW'(i));
        en_n = 1; rdy_n = 1;
        drain("to_burst", 40);
        chk("burst_acc", accs, 12);
        chk("burst_span", last_acc - first_acc + 1, 12);

        // Back-pressure pattern 1-0-0-1
        for (int i = 12; i < 24; i++) fq.push_back(DW'(i));
        n = 0;
        while ((fq.size() != 0 || outst != 0) && n < 100) begin
            rdy_n = (n % 4 == 0) || (n % 4 == 3);
            cycle(); n++;
        end
        chk("bp_acc", accs, 24);
        rdy_n = 1;

        // en dropped after the second word of a packet
        base = pops;
        for (int i = 0; i < 8; i++) fq.push_back(DW'(100 + i));
        n = 0;
        while (pops - base < 2 && n < 20) begin cycle(); n++; end
        en_n = 0;
        repeat (10) cycle();
        chk("drain_pops", pops - base, 4);
        chk("idle_rd_en", last_rd, 0);
        chk("idle_busy", busy, 0);
        en_n = 1;
        drain("to_resume", 40);
        chk("resume_pops", pops - base, 8);

        // Underrun: FIFO runs dry two words into a packet
        for (int i = 0; i < 6; i++) fq.push_back(DW'(200 + i));
        drain("to_pre_ur", 40);
        n = 0;
        while (ucnt < 7 && n < 30) begin cycle(); n++; end
        fq.push_back(DW'(206));
        drain("to_post_ur", 40);
        chk("ucnt7", underrun_cnt, 7);

        // clr with the buffer full
        rdy_n = 0;
        for (int i = 0; i < 5; i++) fq.push_back(DW'(300 + i));
        n = 0;
        while (outst < 2 && n < 20) begin cycle(); n++; end
        repeat (2) cycle();
        clr_n = 1; cycle();
        clr_n = 0; cycle();
        chk("clr_valid", m_valid, 0);
        chk("clr_ucnt", underrun_cnt, 0);
        rdy_n = 1;
        drain("to_clr", 40);

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            rdy_n = ($urandom_range(0, 3) != 0);
            en_n  = ($urandom_range(0, 15) != 0);
            clr_n = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 2) != 0 && fq.size() < 20) fq.push_back(DW'($urandom));
            if ($urandom_range(0, 49) == 0) repeat (12) cycle();
            cycle();
        end
        en_n = 1; rdy_n = 1; clr_n = 0;
        drain("to_rand", 200);

        // Asynchronous reset mid-stream
        for (int i = 0; i < 6; i++) fq.push_back(DW'(500 + i));
        rdy_n = 0;
        repeat (4) cycle();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", m_valid, 0); chk("arst_data", m_data, 0);
        chk("arst_sop", m_sop, 0); chk("arst_eop", m_eop, 0);
        chk("arst_sym", m_sym_idx, 0); chk("arst_rd_en", fifo_rd_en, 0);
        chk("arst_busy", busy, 0); chk("arst_ucnt", underrun_cnt, 0);
        sb.delete(); outst = 0; pops = 0; ucnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        rdy_n = 1;
        drain("to_arst", 60);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
